// File: rtl/tone_curve_pkg.sv
// Shared types and helpers for the tone-curve stage.
// Define TONE_CURVE_INTERP_EN to build the fractional-index interpolating variant.
package tone_curve_pkg;

    typedef enum logic {INIT, RUN} state_e;

`ifdef TONE_CURVE_INTERP_EN
    localparam bit INTERP_EN   = 1'b1;
    localparam int PIPE_STAGES = 3;
`else
    localparam bit INTERP_EN   = 1'b0;
    localparam int PIPE_STAGES = 2;
`endif

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/tone_curve_lane.sv
// One lane: signed clamp to table range, private copy of the curve table, read pipeline.
// TONE_CURVE_INTERP_EN adds a second read port and a linear-interpolation stage.
module tone_curve_lane
    import tone_curve_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 256,
    parameter int FRAC_BITS = 4,
    localparam int ADDR_W   = addr_w(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PIPE_STAGES-1:0] stage_en,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic [WIDTH-1:0]       pix_in,
    output logic [WIDTH-1:0]       val_out
);

    localparam int SHIFT = INTERP_EN ? FRAC_BITS : 0;
    localparam logic signed [WIDTH-1:0] MAXV    = WIDTH'((DEPTH - 1) << SHIFT);
    localparam logic [ADDR_W-1:0]       MAX_IDX = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0]        tbl_mem [DEPTH];
    logic signed [WIDTH-1:0] pix;
    logic [ADDR_W-1:0]       idx_q, idx_d;
    logic [WIDTH-1:0]        val_q, val_d;

    assign pix     = $signed(pix_in);
    assign val_out = val_q;

    // Plain write port: a read in the same cycle sees the old contents.
    always_ff @(posedge clk) begin
        if (wr_en) tbl_mem[wr_addr] <= wr_data;
    end

    always_comb begin
        idx_d = idx_q;
        if (stage_en[0]) begin
            if (pix[WIDTH-1])    idx_d = '0;
            else if (pix > MAXV) idx_d = MAX_IDX;
            else                 idx_d = pix[SHIFT +: ADDR_W];
        end
    end

`ifdef TONE_CURVE_INTERP_EN
    localparam int PW = WIDTH + FRAC_BITS + 2;

    logic [FRAC_BITS-1:0] frac_q, frac_d, frac2_q, frac2_d;
    logic [WIDTH-1:0]     e0_q, e0_d, e1_q, e1_d;
    logic [ADDR_W-1:0]    idx_nx;
    logic signed [PW-1:0] prod;

    assign idx_nx = (idx_q == MAX_IDX) ? idx_q : idx_q + ADDR_W'(1);

    always_comb begin
        frac_d  = frac_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        frac2_d = frac2_q;
        val_d   = val_q;
        prod    = (PW'($signed(e1_q)) - PW'($signed(e0_q))) * PW'($signed({1'b0, frac2_q}));
        if (stage_en[0]) begin
            if (pix[WIDTH-1] || pix > MAXV) frac_d = '0;
            else                            frac_d = pix[FRAC_BITS-1:0];
        end
        if (stage_en[1]) begin
            e0_d    = tbl_mem[idx_q];
            e1_d    = tbl_mem[idx_nx];
            frac2_d = frac_q;
        end
        if (stage_en[2]) val_d = e0_q + WIDTH'(prod >>> FRAC_BITS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            frac_q  <= '0;
            e0_q    <= '0;
            e1_q    <= '0;
            frac2_q <= '0;
            val_q   <= '0;
        end else begin
            idx_q   <= idx_d;
            frac_q  <= frac_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            frac2_q <= frac2_d;
            val_q   <= val_d;
        end
    end
`else
    always_comb begin
        val_d = val_q;
        if (stage_en[1]) val_d = tbl_mem[idx_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            val_q <= '0;
        end else begin
            idx_q <= idx_d;
            val_q <= val_d;
        end
    end
`endif

endmodule

// File: rtl/tone_curve_lut.sv
// Multi-lane programmable tone curve: identity self-fill after reset, then valid/ready streaming lookups.
// Pipeline depth follows TONE_CURVE_INTERP_EN (2 stages without, 3 with).
module tone_curve_lut
    import tone_curve_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 256,
    parameter int CHANNELS  = 1,
    parameter int FRAC_BITS = 4,
    localparam int ADDR_W   = addr_w(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    input  logic                      cfg_wen,
    input  logic [ADDR_W-1:0]         cfg_waddr,
    input  logic [WIDTH-1:0]          cfg_wdata,
    output logic                      cfg_ready,
    output logic                      init_done
);

    localparam logic [ADDR_W-1:0] MAX_IDX = ADDR_W'(DEPTH - 1);
    localparam int LAST = PIPE_STAGES - 1;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      fill_q, fill_d;
    logic [PIPE_STAGES-1:0] vld_q, vld_d, stage_en;
    logic                   adv;
    logic                   accept;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [WIDTH-1:0]       wr_data;

    assign init_done = (state_q == RUN);
    assign cfg_ready = (state_q == RUN);
    assign in_ready  = (state_q == RUN) && stage_en[0];
    assign accept    = in_valid && in_ready;
    assign out_valid = vld_q[LAST];

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        if (state_q == INIT) begin
            fill_d = fill_q + ADDR_W'(1);
            if (fill_q == MAX_IDX) state_d = RUN;
        end
    end

    // A stage may load when it is empty or its contents move on this cycle.
    always_comb begin
        adv            = !vld_q[LAST] || out_ready;
        stage_en[LAST] = adv;
        for (int k = LAST - 1; k >= 0; k--) begin
            adv         = !vld_q[k] || adv;
            stage_en[k] = adv;
        end
    end

    always_comb begin
        vld_d = vld_q;
        if (stage_en[0]) vld_d[0] = accept;
        for (int k = 1; k < PIPE_STAGES; k++) begin
            if (stage_en[k]) vld_d[k] = vld_q[k-1];
        end
    end

    always_comb begin
        wr_en   = (state_q == INIT) || cfg_wen;
        wr_addr = (state_q == INIT) ? fill_q : cfg_waddr;
        wr_data = (state_q == INIT) ? WIDTH'(fill_q) : cfg_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            fill_q  <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            vld_q   <= vld_d;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        tone_curve_lane #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .FRAC_BITS(FRAC_BITS)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .stage_en(stage_en),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .pix_in  (in_data[lane_lsb(k, WIDTH) +: WIDTH]),
            .val_out (out_data[lane_lsb(k, WIDTH) +: WIDTH])
        );
    end

endmodule

// File: tb/tb_tone_curve_lut.sv
// Directed bench for tone_curve_lut (default build): a table/queue model is checked against every output beat.
module tb_tone_curve_lut;

    localparam int WIDTH = 16;
    localparam int DEPTH = 256;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] in_data, out_data;
    logic             cfg_wen, cfg_ready, init_done;
    logic [7:0]       cfg_waddr;
    logic [WIDTH-1:0] cfg_wdata;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chkLat = 1'b1;

    logic [WIDTH-1:0] modelTab [DEPTH];
    logic [WIDTH-1:0] expQ[$];
    int               accQ[$];
    logic [WIDTH-1:0] gotQ[$];
    bit               holdPending = 1'b0;
    logic [WIDTH-1:0] holdData;
    logic [WIDTH-1:0] expVal;
    int               lat;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    tone_curve_lut #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(1), .FRAC_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_wen(cfg_wen), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata),
        .cfg_ready(cfg_ready), .init_done(init_done)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Curve value a pixel must produce: clamp the signed value into the table, then look it up.
    function automatic logic [WIDTH-1:0] modelLookup(input logic [WIDTH-1:0] pix);
        int v;
        v = int'($signed(pix));
        if (v < 0) v = 0;
        else if (v > DEPTH - 1) v = DEPTH - 1;
        return modelTab[v];
    endfunction

    task automatic resetModel();
        for (int i = 0; i < DEPTH; i++) modelTab[i] = WIDTH'(i);
        expQ.delete();
        accQ.delete();
        gotQ.delete();
    endtask

    always @(negedge rst_n) resetModel();

    always @(negedge clk) begin
        if (rst_n) begin
            if (holdPending) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(holdData));
            end
            holdPending = out_valid && !out_ready;
            holdData    = out_data;
            if (cfg_wen && cfg_ready) modelTab[cfg_waddr] = cfg_wdata;
            if (in_valid && in_ready) begin
                expQ.push_back(modelLookup(in_data));
                accQ.push_back(cyc + 1);
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_beat: got %0h, required no beat", out_data);
                end else begin
                    expVal = expQ.pop_front();
                    check("stream_data", 32'(out_data), 32'(expVal));
                    lat = cyc + 1 - accQ.pop_front();
                    if (chkLat) check("latency", 32'(lat), 32'd2);
                end
                gotQ.push_back(out_data);
            end
        end else begin
            holdPending = 1'b0;
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] v, output int waited);
        bit acc;
        in_valid = 1'b1;
        in_data  = v;
        waited   = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!acc && waited < 64);
        if (!acc) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: got no accept, required accept of %0h", v);
        end
    endtask

    task automatic endStream();
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] exp);
        int n = 0;
        while (gotQ.size() == 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (gotQ.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s: got no beat, required %0h", name, exp);
        end else begin
            check(name, 32'(gotQ.pop_front()), 32'(exp));
        end
    endtask

    task automatic waitInit(input bit poke);
        int n = 0;
        bit quiet = 1'b1;
        while (n < 400) begin
            @(posedge clk);
            n++;
            #1;
            if (init_done) break;
            if (in_ready || cfg_ready) quiet = 1'b0;
            cfg_wen = 1'b0;
            if (poke && n == 100) begin
                cfg_wen   = 1'b1;
                cfg_waddr = 8'd20;
                cfg_wdata = 16'hBEEF;
            end
        end
        cfg_wen = 1'b0;
        check("init_cycles", 32'(n), 32'd256);
        check("init_quiet", 32'(quiet), 32'd1);
        check("in_ready_after_init", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int w;
        resetModel();
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        cfg_wen = 1'b0; cfg_waddr = '0; cfg_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        rst_n = 1'b1;
        waitInit(1'b0);

        applyStimulus(16'd0, w);   check("b2b_0", 32'(w), 32'd1);
        applyStimulus(16'd7, w);   check("b2b_7", 32'(w), 32'd1);
        applyStimulus(16'd255, w); check("b2b_255", 32'(w), 32'd1);
        endStream();
        checkOutput("id_0", 16'd0);
        checkOutput("id_7", 16'd7);
        checkOutput("id_255", 16'd255);

        applyStimulus(16'hFFFB, w);
        applyStimulus(16'd2000, w);
        applyStimulus(16'h8000, w);
        applyStimulus(16'd256, w);
        applyStimulus(16'd255, w);
        endStream();
        checkOutput("clamp_neg5", 16'd0);
        checkOutput("clamp_2000", 16'd255);
        checkOutput("clamp_8000", 16'd0);
        checkOutput("clamp_256", 16'd255);
        checkOutput("clamp_255", 16'd255);

        cfg_wen = 1'b1; cfg_waddr = 8'd10; cfg_wdata = 16'h0123;
        @(posedge clk);
        #1;
        cfg_wen = 1'b0;
        applyStimulus(16'd10, w);
        endStream();
        checkOutput("wr_then_rd", 16'h0123);

        applyStimulus(16'd10, w);
        endStream();
        cfg_wen = 1'b1; cfg_waddr = 8'd10; cfg_wdata = 16'h0456;
        @(posedge clk);
        #1;
        cfg_wen = 1'b0;
        checkOutput("rd_same_cycle_old", 16'h0123);
        applyStimulus(16'd10, w);
        endStream();
        checkOutput("rd_after_wr", 16'h0456);

        chkLat = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                int ws;
                applyStimulus(16'd20, ws);
                applyStimulus(16'd21, ws);
                applyStimulus(16'd22, ws);
                endStream();
            end
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        checkOutput("stall_order_20", 16'd20);
        checkOutput("stall_order_21", 16'd21);
        checkOutput("stall_order_22", 16'd22);
        chkLat = 1'b1;

        applyStimulus(16'd10, w);
        applyStimulus(16'd11, w);
        applyStimulus(16'd12, w);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        endStream();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitInit(1'b1);
        applyStimulus(16'd10, w);
        applyStimulus(16'd20, w);
        endStream();
        checkOutput("rst_revert_10", 16'd10);
        checkOutput("ignored_cfg_20", 16'd20);

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        tests++;
        fails++;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
